bp_wormhole_packet_arbiter: RTL and testbench
=============================================

# bp_wormhole_packet_arbiter

Packet-atomic round-robin arbiter that shares one wormhole link among `els_p` wormhole flit streams. Each stream comes from a burst-to-wormhole converter or a concentrator port. The arbiter sits in front of the wormhole link that feeds a wormhole-to-burst converter. It grants one requester per packet and holds the grant from header flit to last flit, so flits from different packets never interleave. Flits pass combinationally with no added latency or bubbles.

## Interface
**Parameters**
- `els_p`, "inv": number of requesters; must be ≥ 2.
- `flit_width_p`, "inv": width of the link flit.
- `cord_width_p`, 0: width of the destination coordinate field at flit bits [cord_width_p-1:0].
- `len_width_p`, "inv": width of the length field at bits [cord_width_p +: len_width_p]. Value = number of flits following the header flit.
- `stall_limit_p`, 1024: watchdog threshold in cycles; used only when the watchdog is compiled in.

**Ports**
- `clk_i` input 1: the single clock.
- `reset_n_i` input 1: reset, asynchronous assert, active-low.
- `link_data_i` input els_p*flit_width_p: requester flits, requester i at slice i.
- `link_v_i` input els_p: per-requester valid.
- `link_ready_and_o` output els_p: per-requester ready.
- `link_data_o` output flit_width_p: flit of the granted requester.
- `link_v_o` output 1: output valid.
- `link_ready_and_i` input 1: downstream ready.
- `grant_id_o` output `BSG_SAFE_CLOG2(els_p)`: requester currently owning, or being granted, the link.
- `stall_err_o` output 1: sticky watchdog error.

## Operation
**State machine**
- `IDLE`: no packet is open.
  - The pick is the first i with `link_v_i[i]` set, searching round-robin from `rr_ptr_r`.
  - If any input is valid, `link_v_o`=1, the output is muxed from the pick, and `link_ready_and_o` = one-hot(pick) & `link_ready_and_i`.
  - On accept (`link_v_o` & `link_ready_and_i`):
    - `rr_ptr_r` ← pick+1, wrapping from els_p-1 to 0.
    - Load `owner_r` ← pick and `cnt_r` ← len field of the header flit.
    - If len ≠ 0, go to `BUSY`. If len == 0 (single-flit packet), stay in `IDLE`.
- `BUSY`: the output is muxed from `owner_r`. All other requesters see ready=0, whatever their valid.
  - Each accept decrements `cnt_r`.
  - An accept with `cnt_r`==1 is the last flit; go to `IDLE`.
- The pointer advances only on header acceptance, never on grant alone.
  - The pick may change between cycles while unaccepted; this is legal because the header has not been consumed.
- The len field is sampled only from the header flit. Len bits in body flits are ignored.
- `cnt_r` width is len_width_p. It never underflows, because `BUSY` is exited at count 1.
- `grant_id_o`: equals the pick in `IDLE` (0 when nothing is valid) and `owner_r` in `BUSY`.

## Timing
- Zero-cycle passthrough: `link_data_o`, `link_v_o` and `link_ready_and_o` are combinational from inputs and state.
- There is no combinational path from `link_ready_and_i` to `link_v_o`.
- Back-to-back packets need no idle cycle:
  - A last-flit accept in cycle t allows a header accept in cycle t+1.
  - A single-flit packet can be accepted every cycle.
- Reset (`reset_n_i`=0, asynchronous):
  - State = `IDLE`, `rr_ptr_r`=0, `cnt_r`=0, `owner_r`=0, `stall_err_o`=0.
  - While reset is asserted: `link_v_o`=0 and `link_ready_and_o`=0.
- Reset mid-packet abandons the packet. Downstream must be reset with it.
- Requester valid dropping in `BUSY` inserts bubbles. The grant is held, and no other requester is granted.
- Downstream backpressure in `BUSY` holds all state.

## Configuration
- Macro `BP_WH_ARB_STALL_WATCHDOG_EN`.
- **When defined:**
  - A saturating cycle counter increments each `BUSY` cycle with `link_v_i[owner_r]`=0 and clears on any owner flit accept or on leaving `BUSY`.
  - Reaching `stall_limit_p` sets `stall_err_o`, which stays set until reset.
- **When undefined:** no counter is built, and `stall_err_o` is tied to 0.

## Structure
- Package `bp_wh_arb_pkg` holds:
  - the state enum {`IDLE`, `BUSY`};
  - a function extracting the len field given cord_width_p and len_width_p;
  - the watchdog counter width constant.
- Sub-module `bp_wormhole_rr_pick`: combinational round-robin picker; inputs are the valid vector and `rr_ptr_r`, outputs are one-hot grant, index, and any-valid.
- Counter, state and output mux live in the top module.

## Test plan
- **Arbitration and atomicity:** els_p=4. Requesters 0 and 2 both present len=3 packets at reset exit.
  - Requester 0 gets all 4 flits contiguously, then requester 2 gets its 4 flits.
  - `rr_ptr_r` ends at 3.
- **Single-flit packets:** requesters 1 and 3 each stream len=0 packets with `link_ready_and_i`=1.
  - Output alternates 1,3,1,3, one flit per cycle, with no idle cycles.
- **Bubble hold:** requester 2 drops valid for 5 cycles mid-packet while requester 0 is valid.
  - `link_ready_and_o[0]` stays 0 throughout.
  - Packet 2 resumes and completes before requester 0 is granted.
- **Backpressure:** `link_ready_and_i` toggles 1,0,1,0 during a len=7 packet.
  - Exactly 8 flits are accepted, in order, and `cnt_r` is unchanged on ready=0 cycles.
- **Reset mid-packet:** assert `reset_n_i`=0 after the 2nd flit of a len=5 packet.
  - Outputs go to 0 immediately.
  - After release, the next header from requester 0 is granted first.
- **Watchdog:** macro defined, stall_limit_p=16, owner valid held low for 16 cycles in `BUSY`.
  - `stall_err_o` is 1 and stays 1 after the packet completes.
  - With the macro undefined, the same stimulus gives `stall_err_o`=0.

Source files
------------

// File: rtl/bp_wormhole_packet_arbiter_pkg.sv
// Shared types and helpers for the packet-atomic wormhole arbiter.
// Holds the FSM state enum, the header length-field extractor and the
// width of the optional stall watchdog counter.
package bp_wh_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } bp_wh_arb_state_e;

    // Widest flit the length extractor accepts; callers zero-extend into it.
    localparam int max_flit_width_gp = 512;

    // Stall watchdog counter width; it saturates, so stall_limit_p must fit.
    localparam int wd_cnt_width_gp = 16;

    // Index width that stays at least one bit wide for a single element.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Length field of a header flit: len_width bits starting at cord_width.
    function automatic logic [31:0] get_len(
        input logic [max_flit_width_gp-1:0] flit,
        input int                           cord_width,
        input int                           len_width
    );
        logic [max_flit_width_gp-1:0] shifted;
        logic [31:0]                  mask;
        shifted = flit >> cord_width;
        mask    = (len_width >= 32) ? 32'hffff_ffff : ((32'd1 << len_width) - 32'd1);
        return shifted[31:0] & mask;
    endfunction

endpackage

// File: rtl/bp_wormhole_packet_arbiter_if.sv
// Link bundle between the requesters, the arbiter and the downstream
// wormhole link. The slave modport is the arbiter's view; the master
// modport is the environment (requesters plus downstream sink).
//
// Handshake: on every channel a flit moves in a cycle where valid and
// ready are both high at the rising clock edge. A valid producer keeps its
// flit stable until accepted; ready may be asserted without valid.
interface bp_wormhole_packet_arbiter_if #(
    parameter int els_p        = 4,
    parameter int flit_width_p = 32
);
    logic [els_p*flit_width_p-1:0] link_data_i;
    logic [els_p-1:0]              link_v_i;
    logic [els_p-1:0]              link_ready_and_o;
    logic [flit_width_p-1:0]       link_data_o;
    logic                          link_v_o;
    logic                          link_ready_and_i;

    modport master (
        output link_data_i,
        output link_v_i,
        input  link_ready_and_o,
        input  link_data_o,
        input  link_v_o,
        output link_ready_and_i
    );

    modport slave (
        input  link_data_i,
        input  link_v_i,
        output link_ready_and_o,
        output link_data_o,
        output link_v_o,
        input  link_ready_and_i
    );
endinterface

// File: rtl/bp_wormhole_packet_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of v_i searching upward
// from rr_ptr_i with wraparound. Returns one-hot grant, its index (0 when
// nothing is valid) and an any-valid flag.
module bp_wormhole_rr_pick
    import bp_wh_arb_pkg::*;
#(
    parameter  int els_p       = 4,
    localparam int id_width_lp = safe_clog2(els_p)
) (
    input  logic [els_p-1:0]       v_i,
    input  logic [id_width_lp-1:0] rr_ptr_i,
    output logic [els_p-1:0]       grant_oh_o,
    output logic [id_width_lp-1:0] grant_id_o,
    output logic                   any_v_o
);
    // One spare bit so ptr + offset never overflows before the wrap.
    localparam int sum_width_lp = id_width_lp + 1;

    logic [sum_width_lp-1:0] cand;
    logic [id_width_lp-1:0]  cand_id;

    // Walk candidates in priority order; the first valid one wins.
    always_comb begin
        grant_oh_o = '0;
        grant_id_o = '0;
        any_v_o    = 1'b0;
        cand       = '0;
        cand_id    = '0;
        for (int k = 0; k < els_p; k++) begin
            cand = {1'b0, rr_ptr_i} + sum_width_lp'(k);
            if (cand >= sum_width_lp'(els_p)) begin
                cand = cand - sum_width_lp'(els_p);
            end
            cand_id = cand[id_width_lp-1:0];
            if (!any_v_o && v_i[cand_id]) begin
                any_v_o             = 1'b1;
                grant_id_o          = cand_id;
                grant_oh_o[cand_id] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bp_wormhole_packet_arbiter.sv
// Packet-atomic round-robin arbiter sharing one wormhole link among els_p
// flit streams. A grant is taken on the header flit and held until the last
// flit of that packet, so packets never interleave. Flits pass through
// combinationally with no added latency.
// Optional feature: define BP_WH_ARB_STALL_WATCHDOG_EN to build a sticky
// watchdog that flags an owner idling for stall_limit_p cycles mid-packet.
module bp_wormhole_packet_arbiter
    import bp_wh_arb_pkg::*;
#(
    parameter  int els_p         = 4,
    parameter  int flit_width_p  = 32,
    parameter  int cord_width_p  = 0,
    parameter  int len_width_p   = 4,
    parameter  int stall_limit_p = 1024,
    localparam int id_width_lp   = safe_clog2(els_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    bp_wormhole_packet_arbiter_if.slave link,
    output logic [id_width_lp-1:0] grant_id_o,
    output logic                   stall_err_o,
    output bp_wh_arb_state_e       state_o,
    output logic [id_width_lp-1:0] rr_ptr_o,
    output logic [len_width_p-1:0] cnt_o
);

    bp_wh_arb_state_e        state_r, state_n;
    logic [id_width_lp-1:0]  rr_ptr_r, rr_ptr_n;
    logic [id_width_lp-1:0]  owner_r, owner_n;
    logic [len_width_p-1:0]  cnt_r, cnt_n;

    logic [els_p-1:0]        pick_oh;
    logic [id_width_lp-1:0]  pick_id;
    logic                    pick_any;

    logic [flit_width_p-1:0] flits [els_p];
    logic [id_width_lp-1:0]  sel;
    logic [flit_width_p-1:0] sel_data;
    logic                    out_v;
    logic [els_p-1:0]        ready_vec;
    logic                    owner_v;

    logic [max_flit_width_gp-1:0] hdr_ext;
    logic [len_width_p-1:0]       hdr_len;

    bp_wormhole_rr_pick #(.els_p(els_p)) u_pick (
        .v_i       (link.link_v_i),
        .rr_ptr_i  (rr_ptr_r),
        .grant_oh_o(pick_oh),
        .grant_id_o(pick_id),
        .any_v_o   (pick_any)
    );

    for (genvar i = 0; i < els_p; i++) begin : g_slice
        assign flits[i] = link.link_data_i[i*flit_width_p +: flit_width_p];
    end

    assign sel_data = flits[sel];
    assign owner_v  = link.link_v_i[owner_r];

    // Zero-extend the muxed flit so the package extractor can read its len.
    always_comb begin
        hdr_ext                     = '0;
        hdr_ext[flit_width_p-1:0]   = sel_data;
    end

    assign hdr_len = len_width_p'(get_len(hdr_ext, cord_width_p, len_width_p));

    // Next-state, counter, pointer and handshake routing for the packet FSM.
    always_comb begin
        state_n   = state_r;
        rr_ptr_n  = rr_ptr_r;
        owner_n   = owner_r;
        cnt_n     = cnt_r;
        sel       = owner_r;
        out_v     = 1'b0;
        ready_vec = '0;
        unique case (state_r)
            IDLE: begin
                sel       = pick_id;
                out_v     = pick_any;
                ready_vec = pick_oh & {els_p{link.link_ready_and_i}};
                if (pick_any && link.link_ready_and_i) begin
                    rr_ptr_n = (pick_id == id_width_lp'(els_p - 1)) ? '0 : pick_id + 1'b1;
                    owner_n  = pick_id;
                    cnt_n    = hdr_len;
                    if (hdr_len != '0) begin
                        state_n = BUSY;
                    end
                end
            end
            BUSY: begin
                sel                = owner_r;
                out_v              = owner_v;
                ready_vec[owner_r] = link.link_ready_and_i;
                if (owner_v && link.link_ready_and_i) begin
                    cnt_n = cnt_r - 1'b1;
                    if (cnt_r == len_width_p'(1)) begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Packet state registers; reset abandons any open packet.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= IDLE;
            rr_ptr_r <= '0;
            owner_r  <= '0;
            cnt_r    <= '0;
        end else begin
            state_r  <= state_n;
            rr_ptr_r <= rr_ptr_n;
            owner_r  <= owner_n;
            cnt_r    <= cnt_n;
        end
    end

    // Outputs are silenced while reset is held, independent of the clock.
    assign link.link_data_o      = sel_data;
    assign link.link_v_o         = out_v & reset_n_i;
    assign link.link_ready_and_o = ready_vec & {els_p{reset_n_i}};
    assign grant_id_o            = (state_r == BUSY) ? owner_r : pick_id;

    assign state_o  = state_r;
    assign rr_ptr_o = rr_ptr_r;
    assign cnt_o    = cnt_r;

`ifdef BP_WH_ARB_STALL_WATCHDOG_EN
    logic [wd_cnt_width_gp-1:0] stall_cnt_r, stall_cnt_n;
    logic                       stall_err_r;
    logic                       owner_accept;

    assign owner_accept = (state_r == BUSY) && owner_v && link.link_ready_and_i;

    // Count BUSY cycles where the owner offers nothing; any owner accept
    // or leaving BUSY clears it, backpressure alone holds it.
    always_comb begin
        stall_cnt_n = stall_cnt_r;
        if ((state_r != BUSY) || owner_accept) begin
            stall_cnt_n = '0;
        end else if (!owner_v && (stall_cnt_r != '1)) begin
            stall_cnt_n = stall_cnt_r + 1'b1;
        end
    end

    // Sticky error once the idle run reaches the limit.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stall_cnt_r <= '0;
            stall_err_r <= 1'b0;
        end else begin
            stall_cnt_r <= stall_cnt_n;
            if (stall_cnt_n >= wd_cnt_width_gp'(stall_limit_p)) begin
                stall_err_r <= 1'b1;
            end
        end
    end

    assign stall_err_o = stall_err_r;
`else
    // No watchdog built; the limit has no meaning and this folds to 0.
    assign stall_err_o = (stall_limit_p < 0);
`endif

endmodule

// File: tb/tb_bp_wormhole_packet_arbiter.sv
// Self-checking bench for bp_wormhole_packet_arbiter: a table of
// single-cycle vectors from reset, directed multi-cycle sequences, and a
// randomized run checked every cycle against a packet-level reference.
module tb_bp_wormhole_packet_arbiter;
    import bp_wh_arb_pkg::*;

    localparam int els_lp    = 4;
    localparam int flit_w_lp = 16;
    localparam int cord_w_lp = 4;
    localparam int len_w_lp  = 4;
    localparam int limit_lp  = 16;
    localparam int id_w_lp   = 2;

`ifdef BP_WH_ARB_STALL_WATCHDOG_EN
    localparam logic exp_wd_lp = 1'b1;
`else
    localparam logic exp_wd_lp = 1'b0;
`endif

    logic                 clk;
    logic                 reset_n;
    logic [id_w_lp-1:0]   grant_id;
    logic                 stall_err;
    bp_wh_arb_state_e     state;
    logic [id_w_lp-1:0]   rr_ptr;
    logic [len_w_lp-1:0]  cnt;

    bp_wormhole_packet_arbiter_if #(.els_p(els_lp), .flit_width_p(flit_w_lp)) link ();

    bp_wormhole_packet_arbiter #(
        .els_p        (els_lp),
        .flit_width_p (flit_w_lp),
        .cord_width_p (cord_w_lp),
        .len_width_p  (len_w_lp),
        .stall_limit_p(limit_lp)
    ) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .link       (link),
        .grant_id_o (grant_id),
        .stall_err_o(stall_err),
        .state_o    (state),
        .rr_ptr_o   (rr_ptr),
        .cnt_o      (cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_cmp;
    int n_bad;
    int seq;

    // Requester flit queues (head = flit currently offered), holds, model.
    logic [flit_w_lp-1:0] rq [els_lp][$];
    logic [els_lp-1:0]    hold;
    int                   m_owner;   // requester with an open packet, -1 if none
    int                   m_left;    // flits still owed by the open packet
    int                   m_last;    // last requester whose header was taken
    int                   acc_log[$];
    logic [els_lp-1:0]    obs_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_left  = 0;
        m_last  = els_lp - 1;
    endtask

    function automatic bit req_v(input int i);
        return (rq[i].size() > 0) && !hold[i];
    endfunction

    function automatic bit any_pending();
        bit p;
        p = (m_owner >= 0);
        for (int i = 0; i < els_lp; i++) if (rq[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic push_pkt(input int r, input int len);
        logic [7:0] tag;
        tag = {2'(r), 6'(seq)};
        seq++;
        rq[r].push_back({tag, 4'(len), 4'($urandom_range(0, 15))});
        for (int b = 0; b < len; b++) rq[r].push_back({tag, 4'($urandom), 4'($urandom)});
    endtask

    task automatic drive_inputs(input bit ds_rdy);
        logic [els_lp-1:0] vv;
        for (int i = 0; i < els_lp; i++) begin
            vv[i] = req_v(i);
            link.link_data_i[i*flit_w_lp +: flit_w_lp] =
                (rq[i].size() > 0) ? rq[i][0] : flit_w_lp'($urandom);
        end
        link.link_v_i         = vv;
        link.link_ready_and_i = ds_rdy;
    endtask

    task automatic do_reset();
        reset_n               = 1'b0;
        link.link_v_i         = '0;
        link.link_data_i      = '0;
        link.link_ready_and_i = 1'b0;
        hold                  = '0;
        for (int i = 0; i < els_lp; i++) rq[i].delete();
        acc_log.delete();
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state), 32'(IDLE));
        chk("rst_rr", 32'(rr_ptr), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_err", 32'(stall_err), 32'd0);
        chk("rst_v", 32'(link.link_v_o), 32'd0);
        reset_n = 1'b1;
    endtask

    // One clock of traffic: drive, compare against the reference, advance.
    task automatic step(input bit ds_rdy);
        logic [els_lp-1:0]    vv;
        logic [els_lp-1:0]    exp_rdy;
        logic [flit_w_lp-1:0] f;
        int                   g;
        bit                   ev;
        drive_inputs(ds_rdy);
        vv = link.link_v_i;
        #1;
        g  = 0;
        ev = 1'b0;
        if (m_owner < 0) begin
            for (int k = 1; k <= els_lp; k++) begin
                int c;
                c = (m_last + k) % els_lp;
                if (!ev && vv[c]) begin
                    ev = 1'b1;
                    g  = c;
                end
            end
        end else begin
            g  = m_owner;
            ev = vv[g];
        end
        exp_rdy = (((m_owner >= 0) || ev) && ds_rdy) ? (els_lp'(1) << g) : '0;
        obs_rdy = link.link_ready_and_o;
        chk("v_o", 32'(link.link_v_o), 32'(ev));
        chk("ready_o", 32'(link.link_ready_and_o), 32'(exp_rdy));
        chk("grant_id", 32'(grant_id), 32'(g));
        chk("state", 32'(state), (m_owner >= 0) ? 32'(BUSY) : 32'(IDLE));
        chk("rr_ptr", 32'(rr_ptr), 32'((m_last + 1) % els_lp));
        if (m_owner >= 0) chk("cnt", 32'(cnt), 32'(m_left));
        if (ev) chk("data_o", 32'(link.link_data_o), 32'(rq[g][0]));
        if (link.link_v_o && link.link_ready_and_i) acc_log.push_back(int'(grant_id));
        if (ev && ds_rdy) begin
            f = rq[g].pop_front();
            if (m_owner < 0) begin
                m_last = g;
                if (f[7:4] != 4'd0) begin
                    m_owner = g;
                    m_left  = int'(f[7:4]);
                end
            end else begin
                m_left--;
                if (m_left == 0) m_owner = -1;
            end
        end
        @(negedge clk);
    endtask

    // mode 0: ready always, 1: toggle 1,0,1,0, 2: random ~75%.
    task automatic run_until_empty(input int mode, input int max_cycles);
        int n;
        n = 0;
        while (any_pending() && n < max_cycles) begin
            case (mode)
                0:       step(1'b1);
                1:       step(n % 2 == 0);
                default: step($urandom_range(0, 3) != 0);
            endcase
            n++;
        end
        chk("drain_timeout", 32'(any_pending()), 32'd0);
    endtask

    // ---------------- table-driven vectors from reset ----------------
    typedef struct {
        logic [3:0]       v;
        logic [3:0]       len;
        logic             rdy;
        logic [1:0]       e_grant;
        logic             e_v;
        logic [3:0]       e_rdy;
        logic [1:0]       e_rr;
        bp_wh_arb_state_e e_state;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "global timeout");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        seq   = 0;
        obs_rdy = '0;
        model_reset();

        vecs[0] = '{4'b0000, 4'd0, 1'b1, 2'd0, 1'b0, 4'b0000, 2'd0, IDLE};
        vecs[1] = '{4'b0001, 4'd0, 1'b1, 2'd0, 1'b1, 4'b0001, 2'd1, IDLE};
        vecs[2] = '{4'b0100, 4'd2, 1'b1, 2'd2, 1'b1, 4'b0100, 2'd3, BUSY};
        vecs[3] = '{4'b1010, 4'd1, 1'b0, 2'd1, 1'b1, 4'b0000, 2'd0, IDLE};
        vecs[4] = '{4'b1000, 4'd0, 1'b1, 2'd3, 1'b1, 4'b1000, 2'd0, IDLE};
        vecs[5] = '{4'b1111, 4'd5, 1'b1, 2'd0, 1'b1, 4'b0001, 2'd1, BUSY};
        vecs[6] = '{4'b1100, 4'd0, 1'b1, 2'd2, 1'b1, 4'b0100, 2'd3, IDLE};

        for (int r = 0; r < 7; r++) begin
            logic [flit_w_lp-1:0] ed;
            do_reset();
            for (int i = 0; i < els_lp; i++)
                link.link_data_i[i*flit_w_lp +: flit_w_lp] = {8'(160 + i), vecs[r].len, 4'(i)};
            link.link_v_i         = vecs[r].v;
            link.link_ready_and_i = vecs[r].rdy;
            ed = {8'(160 + int'(vecs[r].e_grant)), vecs[r].len, 4'(vecs[r].e_grant)};
            #1;
            chk("tbl_grant", 32'(grant_id), 32'(vecs[r].e_grant));
            chk("tbl_v", 32'(link.link_v_o), 32'(vecs[r].e_v));
            chk("tbl_ready", 32'(link.link_ready_and_o), 32'(vecs[r].e_rdy));
            if (vecs[r].e_v) chk("tbl_data", 32'(link.link_data_o), 32'(ed));
            @(posedge clk);
            #1;
            chk("tbl_rr", 32'(rr_ptr), 32'(vecs[r].e_rr));
            chk("tbl_state", 32'(state), 32'(vecs[r].e_state));
            @(negedge clk);
        end

        // Arbitration and atomicity: 0 then 2, four flits each.
        do_reset();
        push_pkt(0, 3);
        push_pkt(2, 3);
        run_until_empty(0, 40);
        chk("atom_count", 32'(acc_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < acc_log.size(); i++)
            chk("atom_order", 32'(acc_log[i]), (i < 4) ? 32'd0 : 32'd2);
        chk("atom_rr_end", 32'(rr_ptr), 32'd3);

        // Single-flit packets stream every cycle, alternating 1 and 3.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_pkt(1, 0);
            push_pkt(3, 0);
        end
        for (int i = 0; i < 8; i++) step(1'b1);
        chk("single_count", 32'(acc_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < acc_log.size(); i++)
            chk("single_order", 32'(acc_log[i]), (i % 2 == 0) ? 32'd1 : 32'd3);

        // Bubble hold: owner 2 stalls, waiting requester 0 stays unready.
        do_reset();
        push_pkt(2, 4);
        step(1'b1);
        step(1'b1);
        push_pkt(0, 0);
        hold[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            chk("bubble_rdy0", 32'(obs_rdy[0]), 32'd0);
        end
        hold[2] = 1'b0;
        run_until_empty(0, 40);
        chk("bubble_count", 32'(acc_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < acc_log.size(); i++)
            chk("bubble_order", 32'(acc_log[i]), (i < 5) ? 32'd2 : 32'd0);

        // Backpressure: ready toggles through a len=7 packet.
        do_reset();
        push_pkt(1, 7);
        run_until_empty(1, 40);
        chk("bp_count", 32'(acc_log.size()), 32'd8);

        // Reset mid-packet: abandon packet 2, then requester 0 wins first.
        do_reset();
        push_pkt(2, 5);
        step(1'b1);
        step(1'b1);
        push_pkt(0, 0);
        push_pkt(3, 0);
        drive_inputs(1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_v", 32'(link.link_v_o), 32'd0);
        chk("midrst_ready", 32'(link.link_ready_and_o), 32'd0);
        chk("midrst_state", 32'(state), 32'(IDLE));
        chk("midrst_rr", 32'(rr_ptr), 32'd0);
        chk("midrst_cnt", 32'(cnt), 32'd0);
        @(negedge clk);
        rq[2].delete();
        model_reset();
        acc_log.delete();
        reset_n = 1'b1;
        run_until_empty(0, 20);
        chk("midrst_count", 32'(acc_log.size()), 32'd2);
        if (acc_log.size() > 0) chk("midrst_first", 32'(acc_log[0]), 32'd0);

        // Watchdog: owner silent for the full limit inside a packet.
        do_reset();
        push_pkt(1, 2);
        step(1'b1);
        hold[1] = 1'b1;
        for (int i = 0; i < limit_lp - 1; i++) step(1'b1);
        chk("wd_before", 32'(stall_err), 32'd0);
        step(1'b1);
        chk("wd_at_limit", 32'(stall_err), 32'(exp_wd_lp));
        hold[1] = 1'b0;
        run_until_empty(0, 20);
        chk("wd_sticky", 32'(stall_err), 32'(exp_wd_lp));

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                int r;
                r = $urandom_range(0, els_lp - 1);
                if (rq[r].size() < 24)
                    push_pkt(r, ($urandom_range(0, 7) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3));
            end
            for (int i = 0; i < els_lp; i++)
                if ($urandom_range(0, 9) == 0) hold[i] = ~hold[i];
            step($urandom_range(0, 3) != 0);
        end
        hold = '0;
        run_until_empty(2, 2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
